// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, datapath select
// codes, ALU operation codes, FSM states and the decoded-instruction record.
package multicycle_control_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_TIPOR  = 7'b0110011;
    localparam logic [6:0] OPC_TIPOU  = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JUMP   = 7'b1101111;

    typedef enum logic [1:0] {
        ORIG_ALU = 2'd0,
        ORIG_MEM = 2'd1,
        ORIG_LUI = 2'd2,
        ORIG_PC4 = 2'd3
    } wd_sel_t;

    typedef enum logic [1:0] {
        PC4   = 2'd0,
        PCBEQ = 2'd1,
        PCIMM = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ANY = 2'd2
    } alu_op_t;

    typedef enum logic {
        ORIG_REG = 1'b0,
        ORIG_IMM = 1'b1
    } alu_src_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    // Instruction class selects the path through the FSM.
    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_REG     = 3'd3,
        CLS_UPPER   = 3'd4,
        CLS_BRANCH  = 3'd5,
        CLS_JUMP    = 3'd6
    } instr_cls_t;

    typedef struct packed {
        instr_cls_t cls;
        alu_op_t    alu_op;
        alu_src_t   alu_src;
        wd_sel_t    wd_sel;
    } decode_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle controller and the datapath/memory side.
interface multicycle_control_if #(
    parameter int unsigned RET_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             mem_req;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       OrigWriteData;
    logic             MemRead;
    logic [1:0]       OrigPC;
    logic [1:0]       ALUOp;
    logic             MemWrite;
    logic             OrigALU;
    logic             RegWrite;
    logic             illegal;
    logic [RET_W-1:0] retired;
    logic [2:0]       state;

    modport master (
        input  opcode, mem_ready,
        output mem_req, ir_write, pc_write, OrigWriteData, MemRead, OrigPC,
               ALUOp, MemWrite, OrigALU, RegWrite, illegal, retired, state
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, ir_write, pc_write, OrigWriteData, MemRead, OrigPC,
               ALUOp, MemWrite, OrigALU, RegWrite, illegal, retired, state
    );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational opcode lookup: instruction class plus the ALU and write-data
// selects that the FSM applies in the phases where the opcode matters.
module control_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0] i_opcode,
    output decode_t    o_dec
);

    // Map opcode to class and per-instruction datapath selects.
    always_comb begin
        o_dec = '{cls: CLS_ILLEGAL, alu_op: OP_ADD, alu_src: ORIG_REG, wd_sel: ORIG_ALU};
        case (i_opcode)
            OPC_LOAD:   o_dec = '{cls: CLS_LOAD,   alu_op: OP_ADD, alu_src: ORIG_IMM, wd_sel: ORIG_MEM};
            OPC_STORE:  o_dec = '{cls: CLS_STORE,  alu_op: OP_ADD, alu_src: ORIG_IMM, wd_sel: ORIG_ALU};
            OPC_TIPOR:  o_dec = '{cls: CLS_REG,    alu_op: OP_ANY, alu_src: ORIG_REG, wd_sel: ORIG_ALU};
            OPC_TIPOU:  o_dec = '{cls: CLS_UPPER,  alu_op: OP_ADD, alu_src: ORIG_IMM, wd_sel: ORIG_LUI};
            OPC_BRANCH: o_dec = '{cls: CLS_BRANCH, alu_op: OP_SUB, alu_src: ORIG_IMM, wd_sel: ORIG_ALU};
            OPC_JUMP:   o_dec = '{cls: CLS_JUMP,   alu_op: OP_ADD, alu_src: ORIG_IMM, wd_sel: ORIG_PC4};
            default:    o_dec = '{cls: CLS_ILLEGAL, alu_op: OP_ADD, alu_src: ORIG_REG, wd_sel: ORIG_ALU};
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// a ready handshake to memory, an illegal-opcode trap and a retire counter.
module multicycle_control #(
    parameter int unsigned RET_W           = 32,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    import multicycle_control_pkg::*;

    state_t           r_state;
    state_t           w_next;
    logic [RET_W-1:0] r_retired;
    decode_t          w_dec;
    logic             w_retire;

    logic     w_mem_req;
    logic     w_ir_write;
    logic     w_pc_write;
    wd_sel_t  w_wd_sel;
    logic     w_mem_read;
    pc_sel_t  w_pc_sel;
    alu_op_t  w_alu_op;
    logic     w_mem_write;
    alu_src_t w_alu_src;
    logic     w_reg_write;

    control_decode u_decode (
        .i_opcode (bus.opcode),
        .o_dec    (w_dec)
    );

    // State register; reset returns to IDLE immediately, which also forces
    // every strobe low through the combinational output logic.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Retired-instruction counter, one increment per retire cycle, wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)         r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + RET_W'(1);
    end

    // Next state and Moore-per-state outputs.
    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_mem_req   = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_wd_sel    = ORIG_ALU;
        w_mem_read  = 1'b0;
        w_pc_sel    = PC4;
        w_alu_op    = OP_ADD;
        w_mem_write = 1'b0;
        w_alu_src   = ORIG_REG;
        w_reg_write = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_dec.cls != CLS_ILLEGAL) begin
                    w_next = S_EXECUTE;
                end else if (TRAP_ON_ILLEGAL) begin
                    w_next = S_TRAP;
                end else begin
                    w_pc_write = 1'b1;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_EXECUTE: begin
                w_alu_op  = w_dec.alu_op;
                w_alu_src = w_dec.alu_src;
                case (w_dec.cls)
                    CLS_LOAD, CLS_STORE: w_next = S_MEMORY;
                    CLS_REG, CLS_UPPER:  w_next = S_WRITEBACK;
                    CLS_BRANCH: begin
                        w_pc_write = 1'b1;
                        w_pc_sel   = PCBEQ;
                        w_retire   = 1'b1;
                        w_next     = S_FETCH;
                    end
                    CLS_JUMP: begin
                        w_reg_write = 1'b1;
                        w_wd_sel    = w_dec.wd_sel;
                        w_pc_write  = 1'b1;
                        w_pc_sel    = PCIMM;
                        w_retire    = 1'b1;
                        w_next      = S_FETCH;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMORY: begin
                w_mem_req   = 1'b1;
                w_alu_op    = w_dec.alu_op;
                w_alu_src   = w_dec.alu_src;
                w_mem_read  = (w_dec.cls == CLS_LOAD);
                w_mem_write = (w_dec.cls == CLS_STORE);
                if (bus.mem_ready) begin
                    if (w_dec.cls == CLS_LOAD) begin
                        w_next = S_WRITEBACK;
                    end else begin
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                        w_next     = S_FETCH;
                    end
                end
            end
            S_WRITEBACK: begin
                // ALU selects stay on the opcode's values so an unregistered
                // ALU result is still valid while it is written back.
                w_alu_op    = w_dec.alu_op;
                w_alu_src   = w_dec.alu_src;
                w_reg_write = 1'b1;
                w_wd_sel    = w_dec.wd_sel;
                w_pc_write  = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.mem_req       = w_mem_req;
    assign bus.ir_write      = w_ir_write;
    assign bus.pc_write      = w_pc_write;
    assign bus.OrigWriteData = w_wd_sel;
    assign bus.MemRead       = w_mem_read;
    assign bus.OrigPC        = w_pc_sel;
    assign bus.ALUOp         = w_alu_op;
    assign bus.MemWrite      = w_mem_write;
    assign bus.OrigALU       = w_alu_src;
    assign bus.RegWrite      = w_reg_write;
    assign bus.illegal       = (r_state == S_TRAP);
    assign bus.retired       = r_retired;
    assign bus.state         = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a vector table for the main
// instruction sequences plus hand-written reset-abort and counter-wrap runs.
module tb_multicycle_control;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3,
                           ST_M = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6;

    typedef struct {
        logic [6:0]  op;
        logic        rdy;
        logic [2:0]  st;
        logic [13:0] ctl;
        logic [31:0] ret;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    multicycle_control_if #(.RET_W(32)) ia ();
    multicycle_control_if #(.RET_W(4))  ib ();

    multicycle_control #(.RET_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ia.master)
    );

    multicycle_control #(.RET_W(4), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ib.master)
    );

    // {mem_req, ir_write, pc_write, wd[1:0], MemRead, OrigPC[1:0], ALUOp[1:0], MemWrite, OrigALU, RegWrite, illegal}
    function automatic logic [13:0] mk(logic req, logic irw, logic pcw, logic [1:0] wd, logic mrd,
                                       logic [1:0] opc, logic [1:0] alu, logic mwr, logic oalu,
                                       logic rw, logic ill);
        return {req, irw, pcw, wd, mrd, opc, alu, mwr, oalu, rw, ill};
    endfunction

    function automatic logic [13:0] ctl_a();
        return {ia.mem_req, ia.ir_write, ia.pc_write, ia.OrigWriteData, ia.MemRead, ia.OrigPC,
                ia.ALUOp, ia.MemWrite, ia.OrigALU, ia.RegWrite, ia.illegal};
    endfunction

    function automatic logic [13:0] ctl_b();
        return {ib.mem_req, ib.ir_write, ib.pc_write, ib.OrigWriteData, ib.MemRead, ib.OrigPC,
                ib.ALUOp, ib.MemWrite, ib.OrigALU, ib.RegWrite, ib.illegal};
    endfunction

    function automatic vec_t v(logic [6:0] op, logic rdy, logic [2:0] st, logic [13:0] ctl, logic [31:0] ret);
        vec_t r;
        r.op = op; r.rdy = rdy; r.st = st; r.ctl = ctl; r.ret = ret;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Expected control words, derived by hand from the state/opcode table.
    logic [13:0] ZERO, F_WAIT, F_RDY, EX_R, WB_R, EX_I, MEM_LD, WB_LD, MEM_ST, MEM_ST_R,
                 EX_BR, EX_J, WB_U, TRAPC, DEC_NOP;
    vec_t tv[$];

    initial begin
        ZERO     = mk(0,0,0,2'd0,0,2'd0,2'd0,0,0,0,0);
        F_WAIT   = mk(1,0,0,2'd0,0,2'd0,2'd0,0,0,0,0);
        F_RDY    = mk(1,1,0,2'd0,0,2'd0,2'd0,0,0,0,0);
        EX_R     = mk(0,0,0,2'd0,0,2'd0,2'd2,0,0,0,0);
        WB_R     = mk(0,0,1,2'd0,0,2'd0,2'd2,0,0,1,0);
        EX_I     = mk(0,0,0,2'd0,0,2'd0,2'd0,0,1,0,0);
        MEM_LD   = mk(1,0,0,2'd0,1,2'd0,2'd0,0,1,0,0);
        WB_LD    = mk(0,0,1,2'd1,0,2'd0,2'd0,0,1,1,0);
        MEM_ST   = mk(1,0,0,2'd0,0,2'd0,2'd0,1,1,0,0);
        MEM_ST_R = mk(1,0,1,2'd0,0,2'd0,2'd0,1,1,0,0);
        EX_BR    = mk(0,0,1,2'd0,0,2'd1,2'd1,0,1,0,0);
        EX_J     = mk(0,0,1,2'd3,0,2'd2,2'd0,0,1,1,0);
        WB_U     = mk(0,0,1,2'd2,0,2'd0,2'd0,0,1,1,0);
        TRAPC    = mk(0,0,0,2'd0,0,2'd0,2'd0,0,0,0,1);
        DEC_NOP  = mk(0,0,1,2'd0,0,2'd0,2'd0,0,0,0,0);

        // TIPOR, all-ready
        tv.push_back(v(7'h33,1,ST_IDLE,ZERO,0));
        tv.push_back(v(7'h33,1,ST_F,F_RDY,0));
        tv.push_back(v(7'h33,1,ST_D,ZERO,0));
        tv.push_back(v(7'h33,0,ST_E,EX_R,0));
        tv.push_back(v(7'h33,1,ST_WB,WB_R,0));
        // LOAD, 2 fetch waits, 3 memory waits
        tv.push_back(v(7'h03,0,ST_F,F_WAIT,1));
        tv.push_back(v(7'h03,0,ST_F,F_WAIT,1));
        tv.push_back(v(7'h03,1,ST_F,F_RDY,1));
        tv.push_back(v(7'h03,1,ST_D,ZERO,1));
        tv.push_back(v(7'h03,1,ST_E,EX_I,1));
        tv.push_back(v(7'h03,0,ST_M,MEM_LD,1));
        tv.push_back(v(7'h03,0,ST_M,MEM_LD,1));
        tv.push_back(v(7'h03,0,ST_M,MEM_LD,1));
        tv.push_back(v(7'h03,1,ST_M,MEM_LD,1));
        tv.push_back(v(7'h03,0,ST_WB,WB_LD,1));
        // STORE, 2 memory waits
        tv.push_back(v(7'h23,1,ST_F,F_RDY,2));
        tv.push_back(v(7'h23,0,ST_D,ZERO,2));
        tv.push_back(v(7'h23,1,ST_E,EX_I,2));
        tv.push_back(v(7'h23,0,ST_M,MEM_ST,2));
        tv.push_back(v(7'h23,0,ST_M,MEM_ST,2));
        tv.push_back(v(7'h23,1,ST_M,MEM_ST_R,2));
        // BRANCH then JUMP
        tv.push_back(v(7'h63,1,ST_F,F_RDY,3));
        tv.push_back(v(7'h63,1,ST_D,ZERO,3));
        tv.push_back(v(7'h63,0,ST_E,EX_BR,3));
        tv.push_back(v(7'h6f,1,ST_F,F_RDY,4));
        tv.push_back(v(7'h6f,1,ST_D,ZERO,4));
        tv.push_back(v(7'h6f,1,ST_E,EX_J,4));
        // TIPOU
        tv.push_back(v(7'h37,1,ST_F,F_RDY,5));
        tv.push_back(v(7'h37,1,ST_D,ZERO,5));
        tv.push_back(v(7'h37,1,ST_E,EX_I,5));
        tv.push_back(v(7'h37,1,ST_WB,WB_U,5));
        // Illegal opcode traps and sticks
        tv.push_back(v(7'h00,1,ST_F,F_RDY,6));
        tv.push_back(v(7'h00,1,ST_D,ZERO,6));
        tv.push_back(v(7'h00,1,ST_TRAP,TRAPC,6));
        tv.push_back(v(7'h00,0,ST_TRAP,TRAPC,6));
        tv.push_back(v(7'h33,1,ST_TRAP,TRAPC,6));
        tv.push_back(v(7'h03,1,ST_TRAP,TRAPC,6));

        ia.opcode = '0; ia.mem_ready = 1'b0;
        ib.opcode = '0; ib.mem_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("reset_state_a", 32'(ia.state), 32'(ST_IDLE));
        chk("reset_ctl_a", 32'(ctl_a()), 32'(ZERO));
        chk("reset_ret_a", ia.retired, 0);
        chk("reset_ret_b", 32'(ib.retired), 0);
        reset = 1'b0;

        foreach (tv[i]) begin
            ia.opcode    = tv[i].op;
            ia.mem_ready = tv[i].rdy;
            #1;
            chk($sformatf("vec%0d_state", i), 32'(ia.state), 32'(tv[i].st));
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_a()), 32'(tv[i].ctl));
            chk($sformatf("vec%0d_ret", i), ia.retired, tv[i].ret);
            @(negedge clock);
        end

        // Reset leaves TRAP; then TIPOR retires, STORE aborted mid-MEMORY.
        reset = 1'b1;
        #1;
        chk("trap_reset_state", 32'(ia.state), 32'(ST_IDLE));
        chk("trap_reset_ill", 32'(ia.illegal), 0);
        @(negedge clock);
        reset = 1'b0;
        ia.opcode = 7'h33; ia.mem_ready = 1'b1;
        repeat (5) @(negedge clock);
        #1;
        chk("pre_abort_ret", ia.retired, 1);
        chk("pre_abort_state", 32'(ia.state), 32'(ST_F));
        ia.opcode = 7'h23;
        repeat (3) @(negedge clock);
        ia.mem_ready = 1'b0;
        @(negedge clock);
        #1;
        chk("abort_pre_state", 32'(ia.state), 32'(ST_M));
        chk("abort_pre_memwrite", 32'(ia.MemWrite), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_memwrite", 32'(ia.MemWrite), 0);
        chk("abort_ctl", 32'(ctl_a()), 32'(ZERO));
        chk("abort_state", 32'(ia.state), 32'(ST_IDLE));
        chk("abort_ret", ia.retired, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("post_abort_state", 32'(ia.state), 32'(ST_F));
        chk("post_abort_ret", ia.retired, 0);
        ia.mem_ready = 1'b0;

        // NOP retire on unknown opcode and 4-bit counter wrap (dut_b is in FETCH).
        chk("b_park_state", 32'(ib.state), 32'(ST_F));
        ib.opcode = 7'h00;
        ib.mem_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            #1;
            chk($sformatf("b%0d_dec_state", k), 32'(ib.state), 32'(ST_D));
            chk($sformatf("b%0d_dec_ctl", k), 32'(ctl_b()), 32'(DEC_NOP));
            @(negedge clock);
            #1;
            chk($sformatf("b%0d_ret", k), 32'(ib.retired), 32'((k + 1) % 16));
            chk($sformatf("b%0d_fetch", k), 32'(ib.state), 32'(ST_F));
        end
        chk("b_wrap_zero", 32'(ib.retired), 0);
        chk("b_no_trap", 32'(ib.illegal), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
